// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_sequencer_if
//  Description : Handshake and multiplexed address/data pin bundle between
//                the RTC control FSM / pad buffer and the bus sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if #(
   parameter int DATA_W = 8
) ();
   logic              start;
   logic              rnw;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] ad_in;
   logic [DATA_W-1:0] ad_out;
   logic              en_tri;
   logic              CS;
   logic              RD;
   logic              WR;
   logic              A_D;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;

   // Controller / pad side: issues requests, observes pins and results
   modport master (
      output start, rnw, addr, wdata, ad_in,
      input  ad_out, en_tri, CS, RD, WR, A_D, busy, done, rdata
   );

   // Sequencer side
   modport slave (
      input  start, rnw, addr, wdata, ad_in,
      output ad_out, en_tri, CS, RD, WR, A_D, busy, done, rdata
   );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_sequencer
//  Description : Parametrised RTC bus-cycle sequencer. Runs an address phase
//                then a data phase (write or read) with programmable setup,
//                strobe, hold and inter-phase gap timing. All pins registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
   parameter int DATA_W  = 8,
   parameter int T_SETUP = 1,
   parameter int T_PULSE = 6,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 10,
   parameter int CNT_W   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   rtc_bus_sequencer_if.slave   bus
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_A_SETUP = 4'd1,
      S_A_PULSE = 4'd2,
      S_A_HOLD  = 4'd3,
      S_GAP     = 4'd4,
      S_D_SETUP = 4'd5,
      S_D_PULSE = 4'd6,
      S_D_HOLD  = 4'd7,
      S_DONE    = 4'd8
   } state_t;

   // Terminal counts: a timed state lasts T cycles, counter runs 0..T-1
   localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'((T_GAP > 0) ? (T_GAP - 1) : 0);
   localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
   localparam bit               C_HAS_GAP    = (T_GAP > 0);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rnw_q, rnw_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] ad_out_q, ad_out_d;
   logic              en_tri_q, en_tri_d;
   logic              cs_q, cs_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              a_d_q, a_d_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next state, counter, request capture, read sampling and Moore pin decode.
   // Pins are decoded from the next state so the registered pins line up
   // with the state register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + C_CNT_ONE;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.start == 1'b1) begin
               state_d = S_A_SETUP;
               rnw_d   = bus.rnw;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
            end
         end
         S_A_SETUP: begin
            if (cnt_q == C_SETUP_LAST) begin
               state_d = S_A_PULSE;
               cnt_d   = '0;
            end
         end
         S_A_PULSE: begin
            if (cnt_q == C_PULSE_LAST) begin
               state_d = S_A_HOLD;
               cnt_d   = '0;
            end
         end
         S_A_HOLD: begin
            if (cnt_q == C_HOLD_LAST) begin
               state_d = C_HAS_GAP ? S_GAP : S_D_SETUP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q == C_GAP_LAST) begin
               state_d = S_D_SETUP;
               cnt_d   = '0;
            end
         end
         S_D_SETUP: begin
            if (cnt_q == C_SETUP_LAST) begin
               state_d = S_D_PULSE;
               cnt_d   = '0;
            end
         end
         S_D_PULSE: begin
            if (cnt_q == C_PULSE_LAST) begin
               state_d = S_D_HOLD;
               cnt_d   = '0;
               // Sample the bus on the edge that closes the read strobe
               if (rnw_q) begin
                  rdata_d = bus.ad_in;
               end
            end
         end
         S_D_HOLD: begin
            if (cnt_q == C_HOLD_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      cs_d     = 1'b1;
      rd_d     = 1'b1;
      wr_d     = 1'b1;
      a_d_d    = 1'b1;
      en_tri_d = 1'b0;
      ad_out_d = ad_out_q;
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);

      case (state_d)
         S_A_SETUP, S_A_HOLD, S_A_PULSE: begin
            cs_d     = 1'b0;
            a_d_d    = 1'b0;
            en_tri_d = 1'b1;
            ad_out_d = addr_d;
            wr_d     = (state_d != S_A_PULSE);
         end
         S_D_SETUP, S_D_HOLD, S_D_PULSE: begin
            cs_d = 1'b0;
            if (rnw_d) begin
               // Pad buffer released for the whole read data phase
               rd_d = (state_d != S_D_PULSE);
            end else begin
               en_tri_d = 1'b1;
               ad_out_d = wdata_d;
               wr_d     = (state_d != S_D_PULSE);
            end
         end
         default: begin
         end
      endcase
   end

   // State, counter, captured request and registered pins
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rnw_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ad_out_q <= '0;
         en_tri_q <= 1'b0;
         cs_q     <= 1'b1;
         rd_q     <= 1'b1;
         wr_q     <= 1'b1;
         a_d_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rnw_q    <= rnw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ad_out_q <= ad_out_d;
         en_tri_q <= en_tri_d;
         cs_q     <= cs_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         a_d_q    <= a_d_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.ad_out = ad_out_q;
   assign bus.en_tri = en_tri_q;
   assign bus.CS     = cs_q;
   assign bus.RD     = rd_q;
   assign bus.WR     = wr_q;
   assign bus.A_D    = a_d_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_sequencer
//  Description : Self-checking bench for rtc_bus_sequencer: default-timing
//                instance and a short-timing instance without gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rtc_bus_sequencer_if #(.DATA_W(8)) bus0 ();
   rtc_bus_sequencer_if #(.DATA_W(8)) bus1 ();

   rtc_bus_sequencer #(
      .DATA_W(8), .T_SETUP(1), .T_PULSE(6), .T_HOLD(2), .T_GAP(10), .CNT_W(6)
   ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   rtc_bus_sequencer #(
      .DATA_W(8), .T_SETUP(2), .T_PULSE(3), .T_HOLD(1), .T_GAP(0), .CNT_W(6)
   ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic cs, rd, wr, a_d, en, busy, done;
   } pins_t;

   typedef struct {
      int         w;
      bit         rnw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rd;
      bit         vary;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   int         ts_of[2] = '{1, 2};
   int         tp_of[2] = '{6, 3};
   int         th_of[2] = '{2, 1};
   int         tg_of[2] = '{10, 0};
   logic [7:0] last_rd[2] = '{8'h00, 8'h00};
   exp_t       sbq0[$];
   exp_t       sbq1[$];
   vec_t       vecs[6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   function automatic pins_t obs(input int w);
      pins_t p;
      if (w == 0) p = '{bus0.CS, bus0.RD, bus0.WR, bus0.A_D, bus0.en_tri, bus0.busy, bus0.done};
      else        p = '{bus1.CS, bus1.RD, bus1.WR, bus1.A_D, bus1.en_tri, bus1.busy, bus1.done};
      return p;
   endfunction

   function automatic logic [7:0] obs_ad(input int w);
      return (w == 0) ? bus0.ad_out : bus1.ad_out;
   endfunction

   function automatic logic [7:0] obs_rdata(input int w);
      return (w == 0) ? bus0.rdata : bus1.rdata;
   endfunction

   task automatic set_in(input int w, input logic s, input logic r,
                         input logic [7:0] a, input logic [7:0] d);
      if (w == 0) begin
         bus0.start = s; bus0.rnw = r; bus0.addr = a; bus0.wdata = d;
      end else begin
         bus1.start = s; bus1.rnw = r; bus1.addr = a; bus1.wdata = d;
      end
   endtask

   task automatic set_adin(input int w, input logic [7:0] v);
      if (w == 0) bus0.ad_in = v;
      else        bus1.ad_in = v;
   endtask

   // Expected pins in cycle k after the start edge, from the phase windows.
   // drv: 0 = ad_out not checked, 1 = address expected, 2 = write data expected
   function automatic pins_t exp_pins(input int k, input bit rnw, input int ts,
                                      input int tp, input int th, input int tg,
                                      output int drv);
      pins_t p;
      int a_p, a_h, g_s, d_s, d_p, d_h, dn;
      a_p = ts;  a_h = a_p + tp; g_s = a_h + th; d_s = g_s + tg;
      d_p = d_s + ts; d_h = d_p + tp; dn = d_h + th;
      p = '{cs:1'b1, rd:1'b1, wr:1'b1, a_d:1'b1, en:1'b0, busy:1'b1, done:1'b0};
      drv = 0;
      if (k < g_s) begin
         p.cs = 1'b0; p.a_d = 1'b0; p.en = 1'b1; drv = 1;
         if (k >= a_p && k < a_h) p.wr = 1'b0;
      end else if (k < d_s) begin
         drv = 1;
      end else if (k < dn) begin
         p.cs = 1'b0;
         if (rnw) begin
            if (k >= d_p && k < d_h) p.rd = 1'b0;
         end else begin
            p.en = 1'b1; drv = 2;
            if (k >= d_p && k < d_h) p.wr = 1'b0;
         end
      end else if (k == dn) begin
         p.done = 1'b1;
      end else begin
         p.busy = 1'b0;
      end
      return p;
   endfunction

   // Drive one transaction from a negedge and check every cycle through the
   // first idle cycle after DONE. abort=1 resets the block mid data strobe.
   task automatic run_txn(input vec_t v, input bit hold, input bit abort);
      int ts, tp, th, tg, d_p, d_h, dn, last, drv, abort_k;
      pins_t e;
      logic [7:0] adin, exp_rd;
      exp_t sb;
      ts = ts_of[v.w]; tp = tp_of[v.w]; th = th_of[v.w]; tg = tg_of[v.w];
      d_p = 2 * ts + tp + th + tg;
      d_h = d_p + tp;
      dn  = d_h + th;
      last = d_h - 1;
      abort_k = abort ? d_p + 1 : -1;
      exp_rd = v.rnw ? v.rd : last_rd[v.w];
      set_in(v.w, 1'b1, v.rnw, v.addr, v.wdata);
      if (!abort) begin
         sb.rdata = exp_rd;
         sb.cyc   = cyc + 1 + dn;
         if (v.w == 0) sbq0.push_back(sb);
         else          sbq1.push_back(sb);
         if (v.rnw) last_rd[v.w] = v.rd;
      end
      for (int k = 0; k <= dn + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         e = exp_pins(k, v.rnw, ts, tp, th, tg, drv);
         chk($sformatf("pins_w%0d_a%h_k%0d", v.w, v.addr, k), 32'(obs(v.w)), 32'(e));
         if (drv == 1) chk($sformatf("ad_out_addr_w%0d_k%0d", v.w, k), 32'(obs_ad(v.w)), 32'(v.addr));
         if (drv == 2) chk($sformatf("ad_out_wdata_w%0d_k%0d", v.w, k), 32'(obs_ad(v.w)), 32'(v.wdata));
         if (k >= dn) chk($sformatf("rdata_hold_w%0d_k%0d", v.w, k), 32'(obs_rdata(v.w)), 32'(exp_rd));
         if (k == 0 && !hold) set_in(v.w, 1'b0, v.rnw, v.addr, v.wdata);
         if (v.vary) adin = v.rd ^ 8'((k - last) * 37);
         else        adin = (k >= d_p && k < d_h) ? v.rd : 8'h00;
         set_adin(v.w, adin);
         if (k == abort_k) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk("abort_pins", 32'(obs(v.w)), 32'(7'b1111000));
            chk("abort_ad_out", 32'(obs_ad(v.w)), 32'h0);
            chk("abort_rdata", 32'(obs_rdata(v.w)), 32'h0);
            last_rd[0] = 8'h00;
            last_rd[1] = 8'h00;
            return;
         end
      end
   endtask

   task automatic done_seen(input int w);
      exp_t e;
      if ((w == 0 && sbq0.size() == 0) || (w == 1 && sbq1.size() == 0)) begin
         chk($sformatf("done_unexpected_w%0d", w), 32'(obs(w).done), 32'h0);
      end else begin
         if (w == 0) e = sbq0.pop_front();
         else        e = sbq1.pop_front();
         chk($sformatf("sb_rdata_w%0d", w), 32'(obs_rdata(w)), 32'(e.rdata));
         chk($sformatf("sb_done_cycle_w%0d", w), 32'(cyc), 32'(e.cyc));
      end
   endtask

   // Scoreboard side: every done pulse must match a queued expectation
   always @(negedge clk) begin
      if (bus0.done === 1'b1) done_seen(0);
      if (bus1.done === 1'b1) done_seen(1);
   end

   initial begin
      vec_t h;
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
      set_adin(0, 8'h00);
      set_adin(1, 8'h00);

      vecs[0] = '{w:0, rnw:1'b0, addr:8'h21, wdata:8'h5A, rd:8'h00, vary:1'b0};
      vecs[1] = '{w:0, rnw:1'b1, addr:8'h22, wdata:8'h00, rd:8'hC3, vary:1'b0};
      vecs[2] = '{w:0, rnw:1'b1, addr:8'h33, wdata:8'hFF, rd:8'h96, vary:1'b1};
      vecs[3] = '{w:0, rnw:1'b0, addr:8'h7F, wdata:8'hA5, rd:8'h00, vary:1'b0};
      vecs[4] = '{w:1, rnw:1'b0, addr:8'h10, wdata:8'h3C, rd:8'h00, vary:1'b0};
      vecs[5] = '{w:1, rnw:1'b1, addr:8'h11, wdata:8'h00, rd:8'h4E, vary:1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_pins_w0", 32'(obs(0)), 32'(7'b1111000));
      chk("reset_pins_w1", 32'(obs(1)), 32'(7'b1111000));
      chk("reset_ad_out_w0", 32'(obs_ad(0)), 32'h0);
      chk("reset_rdata_w0", 32'(obs_rdata(0)), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i], 1'b0, 1'b0);
         @(negedge clk);
      end

      // start held high: second request accepted in the idle cycle after DONE
      h = '{w:0, rnw:1'b0, addr:8'h44, wdata:8'h11, rd:8'h00, vary:1'b0};
      run_txn(h, 1'b1, 1'b0);
      h = '{w:0, rnw:1'b0, addr:8'h55, wdata:8'h22, rd:8'h00, vary:1'b0};
      run_txn(h, 1'b0, 1'b0);
      @(negedge clk);

      // Reset in the middle of a read strobe: abort, no done pulse
      h = '{w:0, rnw:1'b1, addr:8'h66, wdata:8'h00, rd:8'h77, vary:1'b0};
      run_txn(h, 1'b0, 1'b1);
      repeat (40) @(negedge clk);
      chk("post_abort_idle_w0", 32'(obs(0)), 32'(7'b1111000));

      // Recovery after abort
      h = '{w:0, rnw:1'b1, addr:8'h0F, wdata:8'h00, rd:8'hE1, vary:1'b1};
      run_txn(h, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      chk("sb_drain_w0", 32'(sbq0.size()), 32'h0);
      chk("sb_drain_w1", 32'(sbq1.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
